// File: rtl/inst_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : inst_data_arbiter
// Purpose  : Two-master, one-slave Wishbone arbiter that shares one memory port
//            between instruction-cache refills and the core data master. The
//            grant stays with a master for as long as it holds CYC.
// Option   : INST_DATA_ARBITER_ROUND_ROBIN_EN selects round-robin resolution of
//            simultaneous requests. Without it, data has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module inst_data_arbiter #(
    parameter int L2_ADDR_SIZE = 32,
    parameter int L2_BUS_SIZE  = 2,
    localparam int c_DW        = 2 ** (L2_BUS_SIZE + 3),
    localparam int c_SW        = 2 ** L2_BUS_SIZE
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    // instruction cache refill master
    input  logic                    inst_CYC_I,
    input  logic                    inst_STB_I,
    input  logic [L2_ADDR_SIZE-1:0] inst_ADR_I,
    output logic [c_DW-1:0]         inst_DAT_O,
    output logic                    inst_ACK_O,
    // core data master
    input  logic                    data_CYC_I,
    input  logic                    data_STB_I,
    input  logic                    data_WE_I,
    input  logic [c_SW-1:0]         data_SEL_I,
    input  logic [L2_ADDR_SIZE-1:0] data_ADR_I,
    input  logic [c_DW-1:0]         data_DAT_I,
    output logic [c_DW-1:0]         data_DAT_O,
    output logic                    data_ACK_O,
    // memory slave
    output logic                    mem_CYC_O,
    output logic                    mem_STB_O,
    output logic                    mem_WE_O,
    output logic [c_SW-1:0]         mem_SEL_O,
    output logic [L2_ADDR_SIZE-1:0] mem_ADR_O,
    output logic [c_DW-1:0]         mem_DAT_O,
    input  logic [c_DW-1:0]         mem_DAT_I,
    input  logic                    mem_ACK_I
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_GNT_INST = 2'd1;
    localparam logic [1:0] c_ST_GNT_DATA = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic [1:0] w_pick;
    logic       r_last;          // 0 = inst granted most recently, 1 = data
    logic       w_req_inst;
    logic       w_req_data;
    logic       w_prefer_inst;

    assign w_req_inst = inst_CYC_I & inst_STB_I;
    assign w_req_data = data_CYC_I & data_STB_I;

`ifdef INST_DATA_ARBITER_ROUND_ROBIN_EN
    assign w_prefer_inst = r_last;
`else
    // Fixed data priority; last is still tracked but cannot influence the pick.
    assign w_prefer_inst = r_last & 1'b0;
`endif

    always_comb begin
        w_pick = c_ST_IDLE;
        if (w_req_inst && w_req_data) begin
            w_pick = w_prefer_inst ? c_ST_GNT_INST : c_ST_GNT_DATA;
        end else if (w_req_inst) begin
            w_pick = c_ST_GNT_INST;
        end else if (w_req_data) begin
            w_pick = c_ST_GNT_DATA;
        end
    end

    // Release re-arbitrates in the same edge, so handoff has no idle cycle.
    always_comb begin
        w_next = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE:     w_next = w_pick;
            c_ST_GNT_INST: w_next = inst_CYC_I ? c_ST_GNT_INST : w_pick;
            c_ST_GNT_DATA: w_next = data_CYC_I ? c_ST_GNT_DATA : w_pick;
            default:       w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= c_ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_next == c_ST_GNT_INST) begin
                r_last <= 1'b0;
            end else if (w_next == c_ST_GNT_DATA) begin
                r_last <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_CYC_O  = 1'b0;
        mem_STB_O  = 1'b0;
        mem_WE_O   = 1'b0;
        mem_SEL_O  = '0;
        mem_ADR_O  = '0;
        mem_DAT_O  = '0;
        inst_ACK_O = 1'b0;
        inst_DAT_O = '0;
        data_ACK_O = 1'b0;
        data_DAT_O = '0;
        case (r_state)
            c_ST_GNT_INST: begin
                mem_CYC_O  = inst_CYC_I;
                mem_STB_O  = inst_STB_I;
                mem_SEL_O  = '1;
                mem_ADR_O  = inst_ADR_I;
                inst_ACK_O = mem_ACK_I;
                inst_DAT_O = mem_DAT_I;
            end
            c_ST_GNT_DATA: begin
                mem_CYC_O  = data_CYC_I;
                mem_STB_O  = data_STB_I;
                mem_WE_O   = data_WE_I;
                mem_SEL_O  = data_SEL_I;
                mem_ADR_O  = data_ADR_I;
                mem_DAT_O  = data_DAT_I;
                data_ACK_O = mem_ACK_I;
                data_DAT_O = mem_DAT_I;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
